ethernet_header_rx: RTL and testbench
=====================================

# ethernet_header_rx

Link-layer receive stage between the RMII preamble/bit-order front end and `network_rx`. It consumes the post-SFD frame as MSB-first N-bit beats and parses the 14-byte Ethernet header. It filters on destination MAC and classifies the ethertype. For accepted frames it forwards only the payload beats, together with a stable `ethertype_out` select. That select drives `network_rx`'s `ethertype_in`.

## Interface
Parameters:
- `N`, 2, beat width in bits; must divide 8 (1, 2, 4, 8).
- `MY_MAC`, 48'h69_69_5A_06_54_91, this station's MAC address.

Ports:
- `clk` input 1: single system clock.
- `rst` input 1: reset, synchronous, active-high.
- `axiiv` input 1: beat valid; held high for the whole frame, low between frames.
- `axiid` input N: frame beat, MSB-first within byte, bytes in wire order.
- `axiov` output 1: payload beat valid; drives `network_rx.axiiv`.
- `axiod` output N: payload beat; drives `network_rx.axiid`.
- `ethertype_out` output 1: 0 = IPv4 (0x0800), 1 = ARP (0x0806); drives `network_rx.ethertype_in`.
- `dst_mac_out` output 48: destination MAC of the last accepted frame.
- `src_mac_out` output 48: source MAC of the last accepted frame.
- `hdr_valid_out` output 1: one-cycle pulse when a header is accepted.
- `drop_count_out` output 16: count of dropped frames, saturating at 16'hFFFF.

## Operation
- Constant `HDR_BEATS = 112/N`; beat counter width is `$clog2(HDR_BEATS+1)`.
- States:
  - IDLE: waiting for a frame.
  - HEADER: shifting header beats into a 112-bit register.
  - PAYLOAD: forwarding beats.
  - DROP: discarding until `axiiv` is low.
- IDLE → HEADER on `axiiv=1`. That first beat is captured as header beat 0.
- HEADER: shift `{hdr, axiid}` on every valid beat.
  - After beat `HDR_BEATS-1` is captured, evaluate the header:
    - destination = `hdr[111:64]`, source = `hdr[63:16]`, ethertype = `hdr[15:0]`.
    - Accept iff the destination passes the filter (see Configuration) and the ethertype is 0x0800 or 0x0806.
  - Accept → PAYLOAD. Latch the MACs and `ethertype_out`, pulse `hdr_valid_out`.
  - Reject → DROP, increment `drop_count_out`.
- PAYLOAD: each beat with `axiiv=1` is registered to `axiod` with `axiov=1`. On `axiiv=0`, go to IDLE.
- `axiiv=0` during HEADER (runt frame): go to IDLE and increment `drop_count_out`. No payload is emitted and no latched output changes.
- DROP → IDLE on `axiiv=0`.
- `ethertype_out` and both MAC outputs hold their value until the next accepted header. They never change while `axiov` is high.
- The FCS is not stripped; it passes through as trailing payload beats.

## Timing
- Reset values:
  - `axiov=0`, `axiod=0`, `ethertype_out=0`, `hdr_valid_out=0`.
  - `dst_mac_out=0`, `src_mac_out=0`, `drop_count_out=0`.
  - State goes to DROP.
- Because reset enters DROP, a frame in flight when `rst` releases is discarded whole. It is not counted.
- The first frame after reset is recognised only after `axiiv` has been low for at least one cycle.
- Latency is 1 cycle from an input payload beat to `axiov`/`axiod`. `axiov` is 0 for all header beats.
- `hdr_valid_out` and the `ethertype_out` update occur in the same cycle as the first payload beat's `axiov=1`.
  - Consequently `ethertype_out` is valid on or before the first payload beat.
- Frames arriving back-to-back need at least one cycle with `axiiv=0` between them. Without that gap they are treated as one frame.
- `rst` takes priority over every other event, including a simultaneous accept or drop increment.

## Configuration
- `MAC_FILTER_EN` defined: a frame is accepted only if its destination equals `MY_MAC` or 48'hFFFF_FFFF_FFFF.
- `MAC_FILTER_EN` undefined (promiscuous): the destination check always passes; only the ethertype filters.

## Structure
- Shared package `eth_pkg`:
  - `ETHERTYPE_IPV4=16'h0800`, `ETHERTYPE_ARP=16'h0806`, `BROADCAST_MAC`, `ETH_HDR_BYTES=14`.
  - State enum `eth_rx_state_t`.
- One sub-module, `eth_header_filter`: combinational accept/ethertype decode from the 112-bit header. The `MAC_FILTER_EN` conditional lives there.

## Test plan
- N=2, MAC_FILTER_EN on, destination=`MY_MAC`, ethertype 0x0800, 20-byte payload → `axiov` high for exactly 80 beats matching the input, `ethertype_out=0`, `hdr_valid_out` pulses once, `drop_count_out=0`.
- Broadcast destination, ethertype 0x0806, 28-byte payload → 112 beats forwarded, `ethertype_out=1`, `src_mac_out` equal to the sent source MAC.
- Destination 48'h02_00_00_00_00_01 with MAC_FILTER_EN on → no `axiov`, `drop_count_out=1`. With MAC_FILTER_EN off, the same frame is forwarded.
- Ethertype 0x86DD → dropped, count increments. A following valid IPv4 frame after a 1-cycle gap is forwarded normally.
- Runt: `axiiv` deasserted after 30 beats → no output, count increments, MAC outputs unchanged from the previous frame.
- `rst` pulsed mid-payload → all outputs at reset values on the next cycle. The rest of that frame is ignored. The next frame is accepted.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: header layout, ethertypes and rx FSM states.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned ETH_HDR_BYTES  = 14;
  localparam int unsigned ETH_HDR_BITS   = ETH_HDR_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DROP
  } eth_rx_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_header_filter.sv
// Combinational accept/ethertype decode of a captured 14-byte Ethernet header.
// Destination filtering is enabled by defining MAC_FILTER_EN (promiscuous otherwise).
module eth_header_filter
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC = 48'h69_69_5A_06_54_91
) (
  input  logic [ETH_HDR_BITS-1:0] hdr,
  output logic                    accept_c,
  output logic                    is_arp_c
);

  logic [47:0] dst_mac;
  logic [15:0] ethertype;
  logic        dst_ok_c;
  logic        type_ok_c;
  logic        unused_src_c;

  assign dst_mac      = hdr[111:64];
  assign ethertype    = hdr[15:0];
  assign unused_src_c = ^hdr[63:16];

`ifdef MAC_FILTER_EN
  assign dst_ok_c = (dst_mac == MY_MAC) || (dst_mac == BROADCAST_MAC);
`else
  logic unused_dst_c;
  assign unused_dst_c = ^{MY_MAC, dst_mac};
  assign dst_ok_c     = 1'b1;
`endif

  assign is_arp_c  = (ethertype == ETHERTYPE_ARP);
  assign type_ok_c = (ethertype == ETHERTYPE_IPV4) || is_arp_c;
  assign accept_c  = dst_ok_c && type_ok_c;

endmodule

// File: rtl/ethernet_header_rx.sv
// Ethernet header parser: filters on destination/ethertype and forwards payload beats.
// Optional destination filtering via MAC_FILTER_EN (see eth_header_filter).
module ethernet_header_rx
  import eth_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter logic [47:0] MY_MAC = 48'h69_69_5A_06_54_91
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         ethertype_out,
  output logic [47:0]  dst_mac_out,
  output logic [47:0]  src_mac_out,
  output logic         hdr_valid_out,
  output logic [15:0]  drop_count_out
);

  localparam int unsigned HDR_BEATS = ETH_HDR_BITS / N;
  localparam int unsigned CNT_W     = $clog2(HDR_BEATS + 1);

  eth_rx_state_t          state_q, state_d;
  logic [ETH_HDR_BITS-1:0] hdr_q, hdr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    axiov_q, axiov_d;
  logic [N-1:0]            axiod_q, axiod_d;
  logic                    etype_q, etype_d;
  logic [47:0]             dst_q, dst_d;
  logic [47:0]             src_q, src_d;
  logic                    hv_q, hv_d;
  logic [15:0]             drop_q, drop_d;
  logic                    accept_c;
  logic                    is_arp_c;

  eth_header_filter #(.MY_MAC(MY_MAC)) u_filter (
    .hdr      (hdr_q),
    .accept_c (accept_c),
    .is_arp_c (is_arp_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_DROP;
      hdr_q   <= '0;
      cnt_q   <= '0;
      axiov_q <= 1'b0;
      axiod_q <= '0;
      etype_q <= 1'b0;
      dst_q   <= '0;
      src_q   <= '0;
      hv_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
      etype_q <= etype_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      hv_q    <= hv_d;
      drop_q  <= drop_d;
    end
  end

  // The header is judged from hdr_q in the cycle carrying the first payload beat,
  // so hdr_valid/ethertype land together with that beat's axiov.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    axiov_d = 1'b0;
    axiod_d = axiod_q;
    etype_d = etype_q;
    dst_d   = dst_q;
    src_d   = src_q;
    hv_d    = 1'b0;
    drop_d  = drop_q;

    unique case (state_q)
      ST_IDLE: begin
        if (axiiv) begin
          hdr_d   = {hdr_q[ETH_HDR_BITS-N-1:0], axiid};
          cnt_d   = CNT_W'(1);
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (!axiiv) begin
          drop_d  = sat_inc16(drop_q);
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(HDR_BEATS)) begin
          if (accept_c) begin
            dst_d   = hdr_q[111:64];
            src_d   = hdr_q[63:16];
            etype_d = is_arp_c;
            hv_d    = 1'b1;
            axiov_d = 1'b1;
            axiod_d = axiid;
            state_d = ST_PAYLOAD;
          end else begin
            drop_d  = sat_inc16(drop_q);
            state_d = ST_DROP;
          end
        end else begin
          hdr_d = {hdr_q[ETH_HDR_BITS-N-1:0], axiid};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PAYLOAD: begin
        if (axiiv) begin
          axiov_d = 1'b1;
          axiod_d = axiid;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!axiiv) state_d = ST_IDLE;
      end
      default: state_d = ST_DROP;
    endcase
  end

  assign axiov          = axiov_q;
  assign axiod          = axiod_q;
  assign ethertype_out  = etype_q;
  assign dst_mac_out    = dst_q;
  assign src_mac_out    = src_q;
  assign hdr_valid_out  = hv_q;
  assign drop_count_out = drop_q;

endmodule

// File: tb/tb_ethernet_header_rx.sv
// Directed bench for ethernet_header_rx with a payload-beat scoreboard.
module tb_ethernet_header_rx;

  localparam int unsigned N         = 2;
  localparam int unsigned BPB       = 8 / N;
  localparam int          HDR_BEATS = 112 / N;
  localparam logic [47:0] MY_MAC    = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_01;

  logic         clk = 1'b0;
  logic         rst;
  logic         axiiv;
  logic [N-1:0] axiid;
  logic         axiov;
  logic [N-1:0] axiod;
  logic         ethertype_out;
  logic [47:0]  dst_mac_out;
  logic [47:0]  src_mac_out;
  logic         hdr_valid_out;
  logic [15:0]  drop_count_out;

  int checks   = 0;
  int failures = 0;
  int pay_cnt  = 0;
  int hv_cnt   = 0;
  logic exp_et = 1'b0;
  logic prev_ov = 1'b0;
  logic [N-1:0] sb[$];

  ethernet_header_rx #(.N(N), .MY_MAC(MY_MAC)) dut (
    .clk            (clk),
    .rst            (rst),
    .axiiv          (axiiv),
    .axiid          (axiid),
    .axiov          (axiov),
    .axiod          (axiod),
    .ethertype_out  (ethertype_out),
    .dst_mac_out    (dst_mac_out),
    .src_mac_out    (src_mac_out),
    .hdr_valid_out  (hdr_valid_out),
    .drop_count_out (drop_count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: compares forwarded beats against the scoreboard.
  always @(negedge clk) begin
    if (axiov) begin
      pay_cnt++;
      if (!prev_ov) begin
        check("hv_with_first_beat", 64'(hdr_valid_out), 64'd1);
        check("etype_at_first_beat", 64'(ethertype_out), 64'(exp_et));
      end
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check("beat", 64'(axiod), 64'(sb.pop_front()));
    end
    if (hdr_valid_out) hv_cnt++;
    prev_ov = axiov;
  end

  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] et, input int plen, input bit accept,
                            input int stop_at, input int rst_at);
    logic [7:0] b[$];
    logic [7:0] byt;
    int total;
    int k;
    pay_cnt = 0;
    hv_cnt  = 0;
    if (accept) exp_et = (et == 16'h0806);
    for (int i = 5; i >= 0; i--) b.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(src[i*8 +: 8]);
    b.push_back(et[15:8]);
    b.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) b.push_back(8'($urandom));
    total = b.size() * BPB;
    if (stop_at >= 0 && stop_at < total) total = stop_at;
    for (int i = 0; i < total; i++) begin
      @(posedge clk); #1;
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst = 1'b0;
        check("rst_axiov", 64'(axiov), 64'd0);
        check("rst_axiod", 64'(axiod), 64'd0);
        check("rst_hv", 64'(hdr_valid_out), 64'd0);
        check("rst_etype", 64'(ethertype_out), 64'd0);
        check("rst_dst", 64'(dst_mac_out), 64'd0);
        check("rst_src", 64'(src_mac_out), 64'd0);
        check("rst_drop", 64'(drop_count_out), 64'd0);
      end
      byt   = b[i / BPB];
      k     = BPB - 1 - (i % BPB);
      axiiv = 1'b1;
      axiid = byt[k*N +: N];
      if (i == rst_at) rst = 1'b1;
      if (accept && i >= HDR_BEATS && (rst_at < 0 || i < rst_at)) sb.push_back(axiid);
    end
    @(posedge clk); #1;
    rst   = 1'b0;
    axiiv = 1'b0;
    axiid = '0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [47:0] src_a = 48'h00_11_22_33_44_55;
  logic [47:0] src_b = 48'hA0_B1_C2_D3_E4_F5;
  logic [47:0] src_c = 48'h12_34_56_78_9A_BC;
  int exp_drop = 0;

  initial begin
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_axiov", 64'(axiov), 64'd0);
    check("reset_etype", 64'(ethertype_out), 64'd0);
    check("reset_dst", 64'(dst_mac_out), 64'd0);
    check("reset_drop", 64'(drop_count_out), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // IPv4 to this station, 20-byte payload
    send_frame(MY_MAC, src_a, 16'h0800, 20, 1'b1, -1, -1);
    settle();
    check("ipv4_beats", 64'(pay_cnt), 64'd80);
    check("ipv4_hv", 64'(hv_cnt), 64'd1);
    check("ipv4_etype", 64'(ethertype_out), 64'd0);
    check("ipv4_dst", 64'(dst_mac_out), 64'(MY_MAC));
    check("ipv4_drop", 64'(drop_count_out), 64'd0);

    // Broadcast ARP, 28-byte payload
    send_frame(BCAST, src_b, 16'h0806, 28, 1'b1, -1, -1);
    settle();
    check("arp_beats", 64'(pay_cnt), 64'd112);
    check("arp_etype", 64'(ethertype_out), 64'd1);
    check("arp_src", 64'(src_mac_out), 64'(src_b));
    check("arp_dst", 64'(dst_mac_out), 64'(BCAST));

    // Foreign destination: filtered only when MAC filtering is built in
`ifdef MAC_FILTER_EN
    send_frame(OTHER_MAC, src_c, 16'h0800, 10, 1'b0, -1, -1);
    exp_drop++;
    settle();
    check("foreign_beats", 64'(pay_cnt), 64'd0);
    check("foreign_src_kept", 64'(src_mac_out), 64'(src_b));
`else
    send_frame(OTHER_MAC, src_c, 16'h0800, 10, 1'b1, -1, -1);
    settle();
    check("foreign_beats", 64'(pay_cnt), 64'd40);
    check("foreign_dst", 64'(dst_mac_out), 64'(OTHER_MAC));
`endif
    check("foreign_drop", 64'(drop_count_out), 64'(exp_drop));

    // IPv6 ethertype dropped, then IPv4 after a single idle cycle
    send_frame(MY_MAC, src_c, 16'h86DD, 12, 1'b0, -1, -1);
    exp_drop++;
    check("v6_beats", 64'(pay_cnt), 64'd0);
    send_frame(MY_MAC, src_a, 16'h0800, 8, 1'b1, -1, -1);
    settle();
    check("b2b_beats", 64'(pay_cnt), 64'd32);
    check("b2b_hv", 64'(hv_cnt), 64'd1);
    check("b2b_drop", 64'(drop_count_out), 64'(exp_drop));
    check("b2b_src", 64'(src_mac_out), 64'(src_a));

    // Runt: frame ends inside the header
    send_frame(BCAST, src_b, 16'h0806, 20, 1'b0, 30, -1);
    exp_drop++;
    settle();
    check("runt_beats", 64'(pay_cnt), 64'd0);
    check("runt_hv", 64'(hv_cnt), 64'd0);
    check("runt_drop", 64'(drop_count_out), 64'(exp_drop));
    check("runt_dst_kept", 64'(dst_mac_out), 64'(MY_MAC));
    check("runt_src_kept", 64'(src_mac_out), 64'(src_a));
    check("runt_etype_kept", 64'(ethertype_out), 64'd0);

    // Reset mid-payload of an ARP frame, then a normal frame
    send_frame(BCAST, src_b, 16'h0806, 20, 1'b1, -1, HDR_BEATS + 10);
    exp_drop = 0;
    settle();
    check("rstf_beats", 64'(pay_cnt), 64'd10);
    check("rstf_drop", 64'(drop_count_out), 64'd0);
    check("rstf_dst", 64'(dst_mac_out), 64'd0);
    send_frame(MY_MAC, src_c, 16'h0800, 6, 1'b1, -1, -1);
    settle();
    check("post_rst_beats", 64'(pay_cnt), 64'd24);
    check("post_rst_src", 64'(src_mac_out), 64'(src_c));
    check("post_rst_drop", 64'(drop_count_out), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
